hazard_controller: RTL
======================

# hazard_controller

Pipeline sequencer that owns the stall and flush controls of the fetch/decode buffer and the decode/execute-memory buffer. Combinationally detects load-use hazards and taken branches. Sequences multi-cycle return-address pops and interrupt entry with a small FSM. Sits beside the decode stage and reads the execute-side fields of the decode/execute-memory buffer.

## Interface
Parameters:
- POP_PC_CYCLES, 2, cycles the PC is frozen after a pop-PC instruction reaches execute (legal 1..15)
- IRQ_VECTOR, 16'h0000, PC value loaded on interrupt entry

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset_n  in  1  reset, asynchronous, active-low
- i_id_valid  in  1  decode stage holds a real instruction
- i_id_rs1  in  3  decode source register 1
- i_id_rs2  in  3  decode source register 2
- i_id_uses_rs1  in  1  decode instruction reads rs1
- i_id_uses_rs2  in  1  decode instruction reads rs2
- i_ex_mem_read  in  1  execute-stage instruction is a load
- i_ex_write_back  in  1  execute-stage instruction writes a register
- i_ex_rd  in  3  execute-stage destination register
- i_ex_pop_pc  in  1  execute-stage instruction pops PC (RET/RTI)
- i_ex_branch_taken  in  1  branch resolved taken in execute
- i_irq  in  1  interrupt request, level, sampled each cycle
- o_pc_stall  out  1  hold PC
- o_fd_stall  out  1  hold fetch/decode buffer
- o_fd_flush  out  1  clear fetch/decode buffer
- o_de_flush  out  1  load bubble (all-zero controls) into decode/execute-memory buffer
- o_pc_load  out  1  PC takes popped value from memory
- o_irq_push  out  1  decode injects push-PC for interrupt
- o_vector_load  out  1  PC takes IRQ_VECTOR
- o_vector  out  16  constant IRQ_VECTOR
- o_state  out  2  FSM state, for debug
- o_stall_count  out  16  see Configuration
- o_flush_count  out  16  see Configuration

## Operation
- States: RUN=0, POP_WAIT=1, IRQ_PUSH=2, IRQ_VEC=3. 4-bit down-counter pop_cnt, 1-bit irq_pending.
- irq_pending sets on any cycle with i_irq=1. It clears on entry to IRQ_PUSH.
- Load-use hazard: i_ex_mem_read & i_ex_write_back & i_id_valid & ((i_id_uses_rs1 & i_id_rs1==i_ex_rd) | (i_id_uses_rs2 & i_id_rs2==i_ex_rd)).
- RUN, priority order:
  - i_ex_branch_taken: fd_flush=1, de_flush=1; stay in RUN.
  - i_ex_pop_pc: pc_stall=1, fd_flush=1, de_flush=1; pop_cnt<=POP_PC_CYCLES; go to POP_WAIT.
  - Load-use hazard: pc_stall=1, fd_stall=1, de_flush=1; stay in RUN (one bubble).
  - irq_pending (or i_irq) with none of the above: pc_stall=1, fd_flush=1; go to IRQ_PUSH.
  - Otherwise: all controls 0.
- POP_WAIT: pc_stall=1, fd_flush=1, de_flush=1 every cycle; pop_cnt decrements. In the cycle pop_cnt==1, o_pc_load=1 and next state is RUN. Branch, load-use and irq inputs are ignored in this state; irq still latches into irq_pending.
- IRQ_PUSH (1 cycle): o_irq_push=1, pc_stall=1; go to IRQ_VEC.
- IRQ_VEC (1 cycle): o_vector_load=1, fd_flush=1; go to RUN.
- fd_stall and fd_flush are never both 1; flush wins.

## Timing
- All strobes except the IRQ_PUSH/IRQ_VEC/POP_WAIT outputs are combinational from inputs in the same cycle. Those three depend on state only (Moore).
- Pop sequence: PC frozen for exactly POP_PC_CYCLES+1 cycles, counting the RUN detection cycle. o_pc_load fires on the last frozen cycle.
- Interrupt entry: 3 cycles (detect, IRQ_PUSH, IRQ_VEC).
- Reset: while i_reset_n=0, state=RUN, pop_cnt=0, irq_pending=0, counters=0, and every output is forced to 0. o_vector is the exception and reads IRQ_VECTOR. Deassertion mid-sequence resumes in RUN.
- Simultaneous branch_taken and pop_pc in RUN: branch wins; pop is flushed.

## Configuration
- HAZARD_COUNT_EN defined:
  - o_stall_count increments on each cycle with o_pc_stall=1.
  - o_flush_count increments on each cycle with o_de_flush=1.
  - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Not defined: both outputs are tied to 16'h0000 and no counter flops exist.

## Test plan
- Load r3 in EX, decode reads rs2=r3 with uses_rs2=1 -> one cycle of pc_stall=fd_stall=de_flush=1, then all 0.
- Load r3 in EX with i_ex_write_back=0, same decode -> no stall.
- i_ex_pop_pc for 1 cycle, POP_PC_CYCLES=2 -> o_state 0,1,1,0; o_pc_load=1 only on the second POP_WAIT cycle; pc_stall high for 3 cycles.
- i_irq pulse during POP_WAIT -> after return to RUN: IRQ_PUSH (o_irq_push=1), then IRQ_VEC (o_vector_load=1, o_vector=IRQ_VECTOR).
- branch_taken and pop_pc together -> fd_flush=de_flush=1, state stays 0; i_reset_n pulled low in IRQ_PUSH -> all outputs 0 immediately, state 0.
- HAZARD_COUNT_EN defined, 3 load-use stalls -> o_stall_count=3, o_flush_count=3; macro undefined -> both 0.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Decode/execute hazard-control bundle between the pipeline (master) and the hazard controller (slave).
interface hazard_controller_if;
  logic        i_id_valid;
  logic [2:0]  i_id_rs1;
  logic [2:0]  i_id_rs2;
  logic        i_id_uses_rs1;
  logic        i_id_uses_rs2;
  logic        i_ex_mem_read;
  logic        i_ex_write_back;
  logic [2:0]  i_ex_rd;
  logic        i_ex_pop_pc;
  logic        i_ex_branch_taken;
  logic        i_irq;
  logic        o_pc_stall;
  logic        o_fd_stall;
  logic        o_fd_flush;
  logic        o_de_flush;
  logic        o_pc_load;
  logic        o_irq_push;
  logic        o_vector_load;
  logic [15:0] o_vector;
  logic [1:0]  o_state;
  logic [15:0] o_stall_count;
  logic [15:0] o_flush_count;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_mem_read, i_ex_write_back, i_ex_rd, i_ex_pop_pc,
           i_ex_branch_taken, i_irq,
    input  o_pc_stall, o_fd_stall, o_fd_flush, o_de_flush, o_pc_load,
           o_irq_push, o_vector_load, o_vector, o_state,
           o_stall_count, o_flush_count
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_mem_read, i_ex_write_back, i_ex_rd, i_ex_pop_pc,
           i_ex_branch_taken, i_irq,
    output o_pc_stall, o_fd_stall, o_fd_flush, o_de_flush, o_pc_load,
           o_irq_push, o_vector_load, o_vector, o_state,
           o_stall_count, o_flush_count
  );
endinterface

// File: rtl/hazard_controller.sv
// Stall/flush sequencer: RUN strobes are combinational (0 cycles), pop/IRQ phases are registered Moore strobes.
// No backpressure of its own; optional stall/flush counters exist only when HAZARD_COUNT_EN is defined.
module hazard_controller #(
  parameter int unsigned  POP_PC_CYCLES = 2,
  parameter logic [15:0] IRQ_VECTOR    = 16'h0000
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    POP_WAIT = 2'd1,
    IRQ_PUSH = 2'd2,
    IRQ_VEC  = 2'd3
  } state_e;

  localparam logic [3:0] POP_INIT = 4'(POP_PC_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] pop_cnt_q, pop_cnt_d;
  logic       irq_pending_q, irq_pending_d;
  logic       m_pc_stall_q, m_pc_stall_d;
  logic       m_fd_flush_q, m_fd_flush_d;
  logic       m_de_flush_q, m_de_flush_d;
  logic       m_pc_load_q, m_pc_load_d;
  logic       m_irq_push_q, m_irq_push_d;
  logic       m_vec_load_q, m_vec_load_d;

  logic load_use;
  logic run_pc_stall, run_fd_stall, run_fd_flush, run_de_flush;
  logic pc_stall, fd_flush, de_flush;

  assign load_use = hz.i_ex_mem_read & hz.i_ex_write_back & hz.i_id_valid &
                    ((hz.i_id_uses_rs1 & (hz.i_id_rs1 == hz.i_ex_rd)) |
                     (hz.i_id_uses_rs2 & (hz.i_id_rs2 == hz.i_ex_rd)));

  always_comb begin
    state_d       = state_q;
    pop_cnt_d     = pop_cnt_q;
    irq_pending_d = irq_pending_q | hz.i_irq;
    run_pc_stall  = 1'b0;
    run_fd_stall  = 1'b0;
    run_fd_flush  = 1'b0;
    run_de_flush  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.i_ex_branch_taken) begin
          run_fd_flush = 1'b1;
          run_de_flush = 1'b1;
        end else if (hz.i_ex_pop_pc) begin
          run_pc_stall = 1'b1;
          run_fd_flush = 1'b1;
          run_de_flush = 1'b1;
          pop_cnt_d    = POP_INIT;
          state_d      = POP_WAIT;
        end else if (load_use) begin
          run_pc_stall = 1'b1;
          run_fd_stall = 1'b1;
          run_de_flush = 1'b1;
        end else if (irq_pending_q | hz.i_irq) begin
          run_pc_stall  = 1'b1;
          run_fd_flush  = 1'b1;
          irq_pending_d = 1'b0;
          state_d       = IRQ_PUSH;
        end
      end
      POP_WAIT: begin
        if (pop_cnt_q != 4'd0) pop_cnt_d = pop_cnt_q - 4'd1;
        if (pop_cnt_q <= 4'd1) state_d = RUN;
      end
      IRQ_PUSH: state_d = IRQ_VEC;
      IRQ_VEC:  state_d = RUN;
      default:  state_d = RUN;
    endcase

    // Moore strobes are decoded from the next state so they come straight from flops.
    m_pc_stall_d = (state_d == POP_WAIT) || (state_d == IRQ_PUSH);
    m_fd_flush_d = (state_d == POP_WAIT) || (state_d == IRQ_VEC);
    m_de_flush_d = (state_d == POP_WAIT);
    m_pc_load_d  = (state_d == POP_WAIT) && (pop_cnt_d == 4'd1);
    m_irq_push_d = (state_d == IRQ_PUSH);
    m_vec_load_d = (state_d == IRQ_VEC);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= RUN;
      pop_cnt_q     <= 4'd0;
      irq_pending_q <= 1'b0;
      m_pc_stall_q  <= 1'b0;
      m_fd_flush_q  <= 1'b0;
      m_de_flush_q  <= 1'b0;
      m_pc_load_q   <= 1'b0;
      m_irq_push_q  <= 1'b0;
      m_vec_load_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pop_cnt_q     <= pop_cnt_d;
      irq_pending_q <= irq_pending_d;
      m_pc_stall_q  <= m_pc_stall_d;
      m_fd_flush_q  <= m_fd_flush_d;
      m_de_flush_q  <= m_de_flush_d;
      m_pc_load_q   <= m_pc_load_d;
      m_irq_push_q  <= m_irq_push_d;
      m_vec_load_q  <= m_vec_load_d;
    end
  end

  // Combinational RUN strobes must also go quiet while reset is held.
  assign pc_stall = i_reset_n & ((state_q == RUN) ? run_pc_stall : m_pc_stall_q);
  assign fd_flush = i_reset_n & ((state_q == RUN) ? run_fd_flush : m_fd_flush_q);
  assign de_flush = i_reset_n & ((state_q == RUN) ? run_de_flush : m_de_flush_q);

  assign hz.o_pc_stall    = pc_stall;
  assign hz.o_fd_flush    = fd_flush;
  assign hz.o_de_flush    = de_flush;
  assign hz.o_fd_stall    = i_reset_n & (state_q == RUN) & run_fd_stall & ~fd_flush;
  assign hz.o_pc_load     = i_reset_n & m_pc_load_q;
  assign hz.o_irq_push    = i_reset_n & m_irq_push_q;
  assign hz.o_vector_load = i_reset_n & m_vec_load_q;
  assign hz.o_vector      = IRQ_VECTOR;
  assign hz.o_state       = i_reset_n ? state_q : 2'd0;

`ifdef HAZARD_COUNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (pc_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (de_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign hz.o_stall_count = stall_cnt_q;
  assign hz.o_flush_count = flush_cnt_q;
`else
  assign hz.o_stall_count = 16'h0000;
  assign hz.o_flush_count = 16'h0000;
`endif

endmodule
